// File: rtl/core2avl_pkg.sv
`default_nettype none
// ============================================================================
// Module : core2avl_pkg
// Brief  : Shared types and encodings for the core-to-Avalon-MM bridge.
// Rev    : 1.0  initial release
// ============================================================================
package core2avl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int MODE_UNSIGNED = 2;

    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b01;

endpackage : core2avl_pkg
`default_nettype wire

// File: rtl/avl_lane_align.sv
`default_nettype none
// ============================================================================
// Module : avl_lane_align
// Brief  : Combinational byte-lane steering: split detect, per-beat byteenable
//          and write data, and load-data extract with sign/zero extension.
// Rev    : 1.0  initial release
// ============================================================================
module avl_lane_align
    import core2avl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NB         = DATA_WIDTH / 8,
    parameter int OFS        = $clog2(NB)
) (
    input  logic [1:0]            i_size,
    input  logic [OFS-1:0]        i_offset,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_buf0,
    input  logic [DATA_WIDTH-1:0] i_buf1,
    output logic                  o_split,
    output logic                  o_size_ok,
    output logic [NB-1:0]         o_be0,
    output logic [NB-1:0]         o_be1,
    output logic [DATA_WIDTH-1:0] o_wd0,
    output logic [DATA_WIDTH-1:0] o_wd1,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [3:0]              w_nbytes;
    logic [15:0]             w_base;
    logic [2*NB-1:0]         w_mask;
    logic [2*DATA_WIDTH-1:0] w_wide;
    logic [2*DATA_WIDTH-1:0] w_shr;
    logic [DATA_WIDTH-1:0]   w_low;
    logic                    w_sign;

    assign w_nbytes  = 4'd1 << i_size;
    assign w_base    = (16'd1 << w_nbytes) - 16'd1;
    assign w_mask    = w_base[2*NB-1:0] << i_offset;
    assign o_be0     = w_mask[NB-1:0];
    assign o_be1     = w_mask[2*NB-1:NB];
    assign o_split   = (5'(i_offset) + 5'(w_nbytes)) > 5'(NB);
    assign o_size_ok = 32'(i_size) <= OFS;

    assign w_wide = {{DATA_WIDTH{1'b0}}, i_wdata} << {i_offset, 3'b000};
    assign o_wd0  = w_wide[DATA_WIDTH-1:0];
    assign o_wd1  = w_wide[2*DATA_WIDTH-1:DATA_WIDTH];

    // Load path: bring the addressed bytes down to lane 0, then extend.
    assign w_shr = {i_buf1, i_buf0} >> {i_offset, 3'b000};
    assign w_low = w_shr[DATA_WIDTH-1:0];

    always_comb begin
        w_sign = 1'b0;
        case (i_size)
            SZ_B:    w_sign = w_low[7];
            SZ_H:    w_sign = w_low[15];
            SZ_W:    w_sign = w_low[31];
            default: w_sign = w_low[DATA_WIDTH-1];
        endcase
        w_sign = w_sign & ~i_unsigned;
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < 32'(w_nbytes))
                o_rdata[8*i +: 8] = w_low[8*i +: 8];
            else
                o_rdata[8*i +: 8] = {8{w_sign}};
        end
    end

endmodule : avl_lane_align
`default_nettype wire

// File: rtl/core2avl_mm.sv
`default_nettype none
// ============================================================================
// Module : core2avl_mm
// Brief  : Registered core load/store to Avalon-MM bridge with waitrequest
//          handshake, readdatavalid support and two-beat misaligned split.
// Rev    : 1.0  initial release
// ============================================================================
module core2avl_mm
    import core2avl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int USE_RDV    = 1,
    parameter int SPLIT_EN   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              mode,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data2write,
    input  logic [1:0]              rw,
    output logic [DATA_WIDTH-1:0]   data2read,
    output logic                    stall,
    output logic                    fault,
    input  logic [DATA_WIDTH-1:0]   readdata,
    input  logic                    readdatavalid,
    input  logic                    waitrequest,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    read,
    output logic                    write
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_rw;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_buf0, r_buf1;
    logic                  r_read, r_write;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [NB-1:0]         r_be;
    logic [DATA_WIDTH-1:0] r_wd;

    logic [2:0]            w_sel_mode;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [1:0]            w_sel_rw;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic                  w_split, w_size_ok, w_illegal;
    logic [NB-1:0]         w_be0, w_be1;
    logic [DATA_WIDTH-1:0] w_wd0, w_wd1, w_rdata;

    logic                  w_latch, w_fault_nxt, w_cap0, w_cap1, w_adv0;
    logic                  w_read_nxt, w_write_nxt;
    logic [ADDR_WIDTH-1:0] w_address_nxt;
    logic [NB-1:0]         w_be_nxt;
    logic [DATA_WIDTH-1:0] w_wd_nxt;

    // In IDLE the live request drives the lane logic so beat 0 can be registered.
    assign w_sel_mode  = (r_state == ST_IDLE) ? mode       : r_mode;
    assign w_sel_addr  = (r_state == ST_IDLE) ? addr       : r_addr;
    assign w_sel_wdata = (r_state == ST_IDLE) ? data2write : r_wdata;
    assign w_sel_rw    = (r_state == ST_IDLE) ? rw         : r_rw;
    assign w_word_addr = {w_sel_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

    avl_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_size     (w_sel_mode[1:0]),
        .i_offset   (w_sel_addr[OFS-1:0]),
        .i_unsigned (w_sel_mode[MODE_UNSIGNED]),
        .i_wdata    (w_sel_wdata),
        .i_buf0     (r_buf0),
        .i_buf1     (r_buf1),
        .o_split    (w_split),
        .o_size_ok  (w_size_ok),
        .o_be0      (w_be0),
        .o_be1      (w_be1),
        .o_wd0      (w_wd0),
        .o_wd1      (w_wd1),
        .o_rdata    (w_rdata)
    );

    assign w_illegal = (w_sel_rw == 2'b11) | ~w_size_ok | (w_split & (SPLIT_EN == 0));

    always_comb begin
        w_state_nxt   = r_state;
        w_latch       = 1'b0;
        w_fault_nxt   = r_fault;
        w_cap0        = 1'b0;
        w_cap1        = 1'b0;
        w_adv0        = 1'b0;
        w_read_nxt    = r_read;
        w_write_nxt   = r_write;
        w_address_nxt = r_address;
        w_be_nxt      = r_be;
        w_wd_nxt      = r_wd;
        case (r_state)
            ST_IDLE: begin
                if (rw != 2'b00) begin
                    w_latch = 1'b1;
                    if (w_illegal) begin
                        w_state_nxt = ST_DONE;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_ISSUE0;
                        w_fault_nxt   = 1'b0;
                        w_read_nxt    = rw[1];
                        w_write_nxt   = rw[0];
                        w_address_nxt = w_word_addr;
                        w_be_nxt      = w_be0;
                        w_wd_nxt      = w_wd0;
                    end
                end
            end
            ST_ISSUE0: begin
                if (!waitrequest) begin
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    if (r_rw == RW_READ && USE_RDV != 0) begin
                        w_state_nxt = ST_WAIT0;
                    end else begin
                        w_cap0 = (r_rw == RW_READ);
                        w_adv0 = 1'b1;
                    end
                end
            end
            ST_WAIT0: begin
                if (readdatavalid) begin
                    w_cap0 = 1'b1;
                    w_adv0 = 1'b1;
                end
            end
            ST_ISSUE1: begin
                if (!waitrequest) begin
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    if (r_rw == RW_READ && USE_RDV != 0) begin
                        w_state_nxt = ST_WAIT1;
                    end else begin
                        w_cap1      = (r_rw == RW_READ);
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT1: begin
                if (readdatavalid) begin
                    w_cap1      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Beat 0 finished: either launch the second beat or complete.
        if (w_adv0) begin
            if (w_split) begin
                w_state_nxt   = ST_ISSUE1;
                w_read_nxt    = r_rw[1];
                w_write_nxt   = r_rw[0];
                w_address_nxt = w_word_addr + ADDR_WIDTH'(NB);
                w_be_nxt      = w_be1;
                w_wd_nxt      = w_wd1;
            end else begin
                w_state_nxt = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw      <= '0;
            r_fault   <= 1'b0;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_be      <= '0;
            r_wd      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fault   <= w_fault_nxt;
            r_read    <= w_read_nxt;
            r_write   <= w_write_nxt;
            r_address <= w_address_nxt;
            r_be      <= w_be_nxt;
            r_wd      <= w_wd_nxt;
            if (w_latch) begin
                r_mode  <= mode;
                r_addr  <= addr;
                r_wdata <= data2write;
                r_rw    <= rw;
            end
            if (w_cap0) r_buf0 <= readdata;
            if (w_cap1) r_buf1 <= readdata;
        end
    end

    assign read       = r_read;
    assign write      = r_write;
    assign address    = r_address;
    assign byteenable = r_be;
    assign writedata  = r_wd;
    assign fault      = (r_state == ST_DONE) & r_fault;
    assign data2read  = (r_state == ST_DONE && r_rw == RW_READ && !r_fault) ? w_rdata : '0;
    assign stall      = ~reset & ((r_state == ST_IDLE) ? (rw != 2'b00) : (r_state != ST_DONE));

endmodule : core2avl_mm
`default_nettype wire

// File: tb/tb_core2avl_mm.sv
`default_nettype none
// ============================================================================
// Module : tb_core2avl_mm
// Brief  : Directed self-checking bench for core2avl_mm (32-bit bus).
// Rev    : 1.0  initial release
// ============================================================================
module tb_core2avl_mm;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [31:0] addr, data2write, readdata;
    logic [1:0]  rw, rw_b;
    logic        readdatavalid, waitrequest;

    logic [31:0] data2read, address, writedata;
    logic [3:0]  byteenable;
    logic        stall, fault, read, write;

    logic [31:0] data2read_b, address_b, writedata_b;
    logic [3:0]  byteenable_b;
    logic        stall_b, fault_b, read_b, write_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    core2avl_mm #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .USE_RDV(1), .SPLIT_EN(1)) u_dut (
        .clk(clk), .reset(reset), .mode(mode), .addr(addr), .data2write(data2write), .rw(rw),
        .data2read(data2read), .stall(stall), .fault(fault), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest), .address(address),
        .writedata(writedata), .byteenable(byteenable), .read(read), .write(write)
    );

    core2avl_mm #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .USE_RDV(1), .SPLIT_EN(0)) u_dut_nosplit (
        .clk(clk), .reset(reset), .mode(mode), .addr(addr), .data2write(data2write), .rw(rw_b),
        .data2read(data2read_b), .stall(stall_b), .fault(fault_b), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest), .address(address_b),
        .writedata(writedata_b), .byteenable(byteenable_b), .read(read_b), .write(write_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE at posedge+1; returns in IDLE at posedge+1.
    task automatic rd_access(input string tag, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [3:0] exp_be0, input logic [31:0] exp_d);
        bit pending = 0;
        bit done    = 0;
        int beat    = 0;
        mode = m; addr = a; rw = 2'b10; waitrequest = 1'b0; readdatavalid = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            readdatavalid = 1'b0;
            if (pending) begin
                readdatavalid = 1'b1;
                readdata      = (beat == 0) ? d0 : d1;
                beat++;
                pending = 0;
            end
            #1;
            if (read) begin
                if (beat == 0) check({tag, " be0"}, byteenable, exp_be0);
                pending = 1;
            end
            if (!stall) begin
                done = 1;
                check({tag, " data"}, data2read, exp_d);
            end
        end
        check({tag, " done"}, done, 1);
        rw = 2'b00;
        readdatavalid = 1'b0;
        step();
    endtask

    initial begin
        logic [1:0] f_rw   [2];
        logic [2:0] f_mode [2];
        bit         seen_bus;
        f_rw[0] = 2'b11; f_mode[0] = 3'b010;
        f_rw[1] = 2'b10; f_mode[1] = 3'b011;

        reset = 1'b1; mode = '0; addr = '0; data2write = '0; rw = '0; rw_b = '0;
        readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst read", read, 0);
        check("rst write", write, 0);
        check("rst stall", stall, 0);
        check("rst fault", fault, 0);
        check("rst address", address, 0);
        check("rst be", byteenable, 0);
        check("rst wdata", writedata, 0);
        check("rst data2read", data2read, 0);
        reset = 1'b0;
        step();

        // lw 0x100 with two waitrequest cycles
        mode = 3'b010; addr = 32'h100; rw = 2'b10; waitrequest = 1'b1;
        #1;
        check("lw stall idle", stall, 1);
        check("lw read idle", read, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) waitrequest = 1'b0;
            #1;
            check("lw read issue", read, 1);
            check("lw addr issue", address, 32'h100);
            check("lw be issue", byteenable, 4'hF);
            check("lw stall issue", stall, 1);
        end
        step();
        readdatavalid = 1'b1; readdata = 32'h8899AABB;
        #1;
        check("lw read wait", read, 0);
        check("lw stall wait", stall, 1);
        step();
        readdatavalid = 1'b0;
        #1;
        check("lw stall done", stall, 0);
        check("lw data done", data2read, 32'h8899AABB);
        rw = 2'b00;
        step();
        check("lw data after", data2read, 0);
        check("lw stall after", stall, 0);

        rd_access("lb", 3'b000, 32'h103, 32'h80FFFFFF, 32'h0, 4'b1000, 32'hFFFFFF80);
        rd_access("lbu", 3'b100, 32'h103, 32'h80FFFFFF, 32'h0, 4'b1000, 32'h00000080);
        rd_access("lh", 3'b001, 32'h102, 32'h8001FFFF, 32'h0, 4'b1100, 32'hFFFF8001);
        rd_access("lhu split", 3'b101, 32'h103, 32'hAB000000, 32'h000000CD, 4'b1000, 32'h0000CDAB);
        rd_access("lw split", 3'b010, 32'h101, 32'h332211FF, 32'hEEEEEE44, 4'b1110, 32'h44332211);

        // sw 0x11223344 at 0x102, split into two beats
        mode = 3'b010; addr = 32'h102; data2write = 32'h11223344; rw = 2'b01; waitrequest = 1'b0;
        step();
        check("sw b0 write", write, 1);
        check("sw b0 read", read, 0);
        check("sw b0 addr", address, 32'h100);
        check("sw b0 be", byteenable, 4'b1100);
        check("sw b0 wd", writedata, 32'h33440000);
        step();
        check("sw b1 write", write, 1);
        check("sw b1 addr", address, 32'h104);
        check("sw b1 be", byteenable, 4'b0011);
        check("sw b1 wd", writedata, 32'h00001122);
        step();
        check("sw done stall", stall, 0);
        check("sw done write", write, 0);
        check("sw done data", data2read, 0);
        rw = 2'b00;
        step();

        // aligned sb: three-cycle write
        mode = 3'b000; addr = 32'h201; data2write = 32'h000000A5; rw = 2'b01;
        step();
        check("sb be", byteenable, 4'b0010);
        check("sb wd", writedata, 32'h0000A500);
        step();
        check("sb done stall", stall, 0);
        rw = 2'b00;
        step();

        // illegal requests fault with no bus cycle
        for (int k = 0; k < 2; k++) begin
            mode = f_mode[k]; addr = 32'h100; rw = f_rw[k];
            #1;
            check("flt stall idle", stall, 1);
            step();
            check("flt fault", fault, 1);
            check("flt stall", stall, 0);
            check("flt bus", {read, write}, 2'b00);
            check("flt data", data2read, 0);
            rw = 2'b00;
            step();
            check("flt fault clr", fault, 0);
        end

        // misaligned lhu on the non-splitting instance
        mode = 3'b101; addr = 32'h103; rw_b = 2'b10; readdata = 32'hAB000000;
        seen_bus = 0;
        #1;
        check("nosplit stall idle", stall_b, 1);
        step();
        seen_bus = read_b | write_b;
        check("nosplit fault", fault_b, 1);
        check("nosplit data", data2read_b, 0);
        check("nosplit stall", stall_b, 0);
        rw_b = 2'b00;
        step();
        seen_bus = seen_bus | read_b | write_b;
        check("nosplit no bus", seen_bus, 0);
        check("nosplit fault clr", fault_b, 0);

        // reset in WAIT0 abandons the read
        mode = 3'b010; addr = 32'h200; rw = 2'b10; waitrequest = 1'b0;
        step();
        check("rstw issue read", read, 1);
        step();
        check("rstw wait stall", stall, 1);
        reset = 1'b1;
        #1;
        check("rstw read", read, 0);
        check("rstw write", write, 0);
        check("rstw stall", stall, 0);
        rw = 2'b00;
        #2;
        reset = 1'b0;
        step();
        readdatavalid = 1'b1; readdata = 32'hDEADBEEF;
        #1;
        check("late rdv stall", stall, 0);
        check("late rdv data", data2read, 0);
        step();
        readdatavalid = 1'b0;
        check("late rdv data2", data2read, 0);
        check("late rdv stall2", stall, 0);
        rd_access("lw post-rst", 3'b010, 32'h200, 32'h12345678, 32'h0, 4'hF, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_core2avl_mm
`default_nettype wire

// File: doc/core2avl_mm.md
Name: core2avl_mm

Overview:
Registered core-to-Avalon-MM data-port bridge with a parametrised bus width. It sits between the core load/store unit and the Avalon interconnect. It runs a handshake FSM that holds each request until the slave releases waitrequest, supports pipelined reads via readdatavalid, and splits misaligned accesses into two bus beats. It returns sign- or zero-extended load data and holds the core stalled until the access completes.

Parameters:
DATA_WIDTH, 32, bus and core data width; 32 or 64 only; NB = DATA_WIDTH/8, OFS = log2(NB).
ADDR_WIDTH, 32, byte-address width.
USE_RDV, 1, 1: read data returns on readdatavalid; 0: read data is valid in the cycle waitrequest is low.
SPLIT_EN, 1, 1: misaligned accesses are split into two beats; 0: misaligned accesses fault with no bus cycle.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mode  in  3  [1:0] size log2 (0 B, 1 H, 2 W, 3 D); [2] unsigned-load flag
addr  in  ADDR_WIDTH  byte address
data2write  in  DATA_WIDTH  store data, LSB-aligned
rw  in  2  {read, write}; 00 idle, 11 illegal
data2read  out  DATA_WIDTH  extended load data
stall  out  1  core must hold mode, addr, data2write and rw stable while high
fault  out  1  one-cycle pulse in DONE for an illegal or unsplittable request
readdata  in  DATA_WIDTH  Avalon read data
readdatavalid  in  1  Avalon read-data valid (ignored when USE_RDV=0)
waitrequest  in  1  Avalon waitrequest
address  out  ADDR_WIDTH  word-aligned address; low OFS bits are 0
writedata  out  DATA_WIDTH  lane-steered write data
byteenable  out  NB  byte lanes
read  out  1  Avalon read
write  out  1  Avalon write

Behaviour:
- Reset (asynchronous, active-high): FSM returns to IDLE. read, write, fault and stall are 0. address, writedata, byteenable and data2read are 0. A bus cycle in flight is abandoned immediately.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE, rw != 0: latch mode, addr, data2write and rw; stall goes high combinationally in this same cycle.
  - Illegal request → DONE with fault. Illegal means rw=11, size > log2(NB), or misaligned with SPLIT_EN=0.
  - Legal request → ISSUE0.
- Misaligned: (addr[OFS-1:0] + 2^size) > NB.
  - Beat 0 uses word addr; beat 1 uses word addr + NB.
  - Build the 2*NB-bit mask ((1<<2^size)-1) << offset; beat 0 takes the low NB bits, beat 1 the high NB bits.
  - Write data is steered as {0, data2write} << (8*offset) over 2*DATA_WIDTH bits; beat 0 takes the low half, beat 1 the high half.
- ISSUE0 / ISSUE1: read or write, address, byteenable and writedata are registered outputs, stable until waitrequest=0 is sampled.
  - Write accepted: advance to ISSUE1 if split, otherwise DONE.
  - Read accepted with USE_RDV=1: go to WAIT0/1. Read accepted with USE_RDV=0: capture readdata into that beat's buffer and advance.
- WAIT0 / WAIT1: read deasserted; wait for readdatavalid; capture readdata into that beat's buffer, then advance to ISSUE1 or DONE.
- No new command is issued before the previous read data returns; at most 1 read is outstanding.
- DONE:
  - stall=0 and data2read is valid for this cycle only.
  - Load data = ({buf1, buf0} >> 8*offset), truncated to 2^size bytes, sign-extended if mode[2]=0, otherwise zero-extended.
  - Stores and faults return data2read=0.
  - Next state is IDLE unconditionally; the request still visible on rw in this cycle is ignored.
- Latency, aligned access with waitrequest=0 and readdatavalid one cycle later: read completes in 4 cycles including DONE; write in 3.
- A readdatavalid outside WAIT0/WAIT1 is ignored.
- A size-3 access is legal only when DATA_WIDTH=64.

Decomposition:
- Shared package core2avl_pkg: FSM state enum, size encodings (SZ_B/H/W/D), MODE_UNSIGNED bit index, RW_READ/RW_WRITE constants.
- Sub-module avl_lane_align (purely combinational, parametrised by DATA_WIDTH): computes the split flag, per-beat byteenable, per-beat writedata, and the read extract/extend.
- The top level holds the FSM, the latched request and the beat buffers.

Test Plan:
- DW=32, lw addr 0x100, waitrequest 2 cycles, readdatavalid +1 cycle, readdata 0x8899AABB → read stays high 3 cycles at 0x100 with be=1111; data2read=0x8899AABB in DONE; stall low only in DONE.
- lb addr 0x103, readdata 0x80FFFFFF → be=1000, data2read=0xFFFFFF80; repeat as lbu → 0x00000080.
- sw data 0x11223344 at addr 0x102 → beat 0: 0x100, be=1100, writedata=0x33440000; beat 1: 0x104, be=0011, writedata=0x00001122.
- Misaligned lhu at 0x103 with SPLIT_EN=1, readdata 0xAB000000 then 0x000000CD → data2read=0x0000CDAB. Same access with SPLIT_EN=0 → no read asserted; fault pulse; data2read=0.
- rw=11, and DW=32 with mode size 3 → fault, zero bus activity.
- Reset asserted in WAIT0 → read/write/stall drop asynchronously; a late readdatavalid is ignored; the next lw completes normally.
